// File: rtl/hclk_ser4_gearbox_pkg.sv
// Shared defaults and helper definitions for the hclk 4:1 serializer slice.
package hclk_ser4_gearbox_pkg;

  localparam int unsigned SER_RATIO_DEF = 4;
  localparam int unsigned SER_SYM_W_DEF = 8;
  localparam logic [7:0]  SER_IDLE_DEF  = 8'h00;

  // Action taken by the shift register on a given hclkin edge.
  typedef enum logic [1:0] {
    LOAD_NONE,
    LOAD_WORD,
    LOAD_IDLE
  } load_e;

  function automatic int unsigned phase_w(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/hclk_ser4_gearbox_fifo.sv
// Two-entry word FIFO feeding the serializer shift register.
module ser_fifo2 #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hclk_ser4_gearbox.sv
// Fabric-side RATIO:1 transmit gearbox: parallel words in, one symbol per hclkin out.
module hclk_ser4_gearbox
  import hclk_ser4_gearbox_pkg::*;
#(
  parameter int unsigned      SYM_W    = SER_SYM_W_DEF,
  parameter int unsigned      RATIO    = SER_RATIO_DEF,
  parameter logic [SYM_W-1:0] IDLE_SYM = SYM_W'(SER_IDLE_DEF),
  localparam int unsigned     PW       = phase_w(RATIO),
  localparam int unsigned     WW       = RATIO * SYM_W
) (
  input  logic             hclkin,
  input  logic             resetn,
  input  logic [WW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SYM_W-1:0] ser_data,
  output logic             ser_first,
  output logic [PW-1:0]    slot_phase,
  output logic             underrun,
  input  logic             underrun_clr
);

  logic [PW-1:0] phase;
  logic          boundary;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [1:0]    count;
  logic [WW-1:0] head;
  logic [WW-1:0] shreg;
  logic          armed;
  load_e         action;

  assign slot_phase = phase;
  assign boundary   = (phase == PW'(RATIO - 1));
  assign in_ready   = (count < 2'd2);
  assign push       = in_valid & ~full;
  assign pop        = boundary & ~empty;

  ser_fifo2 #(.W(WW)) u_fifo (
    .clk   (hclkin),
    .rst_n (resetn),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    action = LOAD_NONE;
    if (boundary) action = empty ? LOAD_IDLE : LOAD_WORD;
  end

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) phase <= '0;
    else         phase <= boundary ? '0 : phase + PW'(1);
  end

  // The shift register always holds the next symbol in its low slot, so the
  // load edge emits symbol 0 directly and stores the word pre-shifted.
  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      shreg     <= {RATIO{IDLE_SYM}};
      ser_data  <= IDLE_SYM;
      ser_first <= 1'b0;
    end else begin
      case (action)
        LOAD_WORD: begin
          shreg     <= head >> SYM_W;
          ser_data  <= head[SYM_W-1:0];
          ser_first <= 1'b1;
        end
        LOAD_IDLE: begin
          shreg     <= {RATIO{IDLE_SYM}};
          ser_data  <= IDLE_SYM;
          ser_first <= 1'b0;
        end
        default: begin
          shreg     <= shreg >> SYM_W;
          ser_data  <= shreg[SYM_W-1:0];
          ser_first <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      underrun <= 1'b0;
      armed    <= 1'b0;
    end else begin
      if (action == LOAD_IDLE && armed) underrun <= 1'b1;
      else if (underrun_clr)            underrun <= 1'b0;
      if (push) armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hclk_ser4_gearbox.sv
// Scoreboard bench for hclk_ser4_gearbox against a queue-based reference model.
module tb_hclk_ser4_gearbox;

  localparam int unsigned SYM_W = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned WW    = SYM_W * RATIO;
  localparam logic [7:0]  IDLE  = 8'h00;

  logic          hclkin       = 1'b0;
  logic          resetn       = 1'b1;
  logic [WW-1:0] in_data      = '0;
  logic          in_valid     = 1'b0;
  logic          underrun_clr = 1'b0;
  logic          in_ready;
  logic [7:0]    ser_data;
  logic          ser_first;
  logic [1:0]    slot_phase;
  logic          underrun;

  hclk_ser4_gearbox #(
    .SYM_W    (SYM_W),
    .RATIO    (RATIO),
    .IDLE_SYM (IDLE)
  ) dut (
    .hclkin       (hclkin),
    .resetn       (resetn),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ser_data     (ser_data),
    .ser_first    (ser_first),
    .slot_phase   (slot_phase),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 hclkin = ~hclkin;

  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       und;
    int         phase;
    logic       ready;
  } exp_t;

  exp_t expq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: words waiting, symbols still to be emitted, slot counter.
  logic [WW-1:0] m_fifo[$];
  logic [7:0]    m_pend[$];
  int            m_phase = 0;
  bit            m_und   = 0;
  bit            m_armed = 0;
  bit            m_took  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [WW-1:0] d, input bit clr);
    exp_t          e;
    logic [WW-1:0] w;
    bit            load_idle;
    @(negedge hclkin);
    in_valid     = v;
    in_data      = d;
    underrun_clr = clr;
    m_took    = v && (m_fifo.size() < 2);
    load_idle = 0;
    e.first   = 0;
    if (m_phase == RATIO - 1) begin
      m_pend.delete();
      if (m_fifo.size() > 0) begin
        w = m_fifo.pop_front();
        for (int k = 0; k < RATIO; k++) m_pend.push_back(w[k*SYM_W +: SYM_W]);
        e.first = 1;
      end else begin
        for (int k = 0; k < RATIO; k++) m_pend.push_back(IDLE);
        load_idle = 1;
      end
    end
    e.data = (m_pend.size() > 0) ? m_pend.pop_front() : IDLE;
    if (load_idle && m_armed) m_und = 1;
    else if (clr)             m_und = 0;
    if (m_took) begin
      m_fifo.push_back(d);
      m_armed = 1;
    end
    m_phase = (m_phase + 1) % RATIO;
    e.und   = m_und;
    e.phase = m_phase;
    e.ready = (m_fifo.size() < 2);
    @(posedge hclkin);
    expq.push_back(e);
  endtask

  task automatic apply_reset();
    resetn       = 1'b0;
    in_valid     = 1'b0;
    underrun_clr = 1'b0;
    m_fifo.delete();
    m_pend.delete();
    m_phase = 0;
    m_und   = 0;
    m_armed = 0;
    #1;
    chk("rst_ser_data", 32'(ser_data), 32'(IDLE));
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ser_first", 32'(ser_first), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_slot_phase", 32'(slot_phase), 32'd0);
    repeat (2) @(posedge hclkin);
    #2;
    resetn = 1'b1;
  endtask

  task automatic align(input int ph);
    for (int i = 0; i < RATIO && m_phase != ph; i++) step(0, '0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge hclkin);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ser_data", 32'(ser_data), 32'(e.data));
        chk("ser_first", 32'(ser_first), 32'(e.first));
        chk("underrun", 32'(underrun), 32'(e.und));
        chk("slot_phase", 32'(slot_phase), 32'(e.phase));
        chk("in_ready", 32'(in_ready), 32'(e.ready));
      end
    end
  end

  initial begin : driver
    logic [WW-1:0] words[3];
    int            idx;
    int            budget;

    apply_reset();

    // Idle after reset: no underrun before the first word.
    repeat (12) step(0, '0, 0);

    // Single word pushed at phase 2, then starvation.
    align(2);
    step(1, 32'h44332211, 0);
    repeat (10) step(0, '0, 0);

    // Back-to-back words with valid held; full buffer meets the load edge.
    step(0, '0, 1);
    words[0] = 32'hA3A2A1A0;
    words[1] = 32'hB3B2B1B0;
    words[2] = 32'hC3C2C1C0;
    idx    = 0;
    budget = 40;
    while (idx < 3 && budget > 0) begin
      step(1, words[idx], 0);
      if (m_took) idx++;
      budget--;
    end
    chk("b2b_accept_budget", 32'(idx), 32'd3);
    repeat (16) step(0, '0, 0);

    // Underrun set wins over clear on the same edge, clear alone next cycle.
    align(0);
    repeat (RATIO) step(0, '0, 1);
    step(0, '0, 1);
    step(0, '0, 0);

    // Reset in the middle of a word with the buffer full.
    align(2);
    step(1, 32'hDDCCBBAA, 0);
    step(1, 32'h99887766, 0);
    step(1, 32'h55443322, 0);
    @(negedge hclkin);
    #2;
    apply_reset();
    repeat (12) step(0, '0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 2) != 0), $urandom(), bit'($urandom_range(0, 11) == 0));
    end
    repeat (8) step(0, '0, 0);

    budget = 8;
    while (expq.size() > 0 && budget > 0) begin
      @(posedge hclkin);
      budget--;
    end
    chk("scoreboard_drain", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
